pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It decides each cycle whether the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold, take a bubble or flush. Three sources are arbitrated: data-cache wait, load-use hazard, and taken branch. Its `IDEXhold_o` drives the ID/EX register's hold enable (`IDEXenable_i`, 1 = hold). It also keeps a stall-cycle performance counter and a memory-timeout flag.

---
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 97 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard/memory inputs and stall/flush controls.
interface pipeline_hazard_ctrl_if;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RDaddr_i;
  logic [4:0]  IFID_RS1addr_i;
  logic [4:0]  IFID_RS2addr_i;
  logic        Branch_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        PCWrite_o;
  logic        IFIDstall_o;
  logic        IFIDflush_o;
  logic        IDEXhold_o;
  logic        IDEXbubble_o;
  logic        EXMEMhold_o;
  logic        MEMWBbubble_o;
  logic [31:0] stall_cnt_o;
  logic        timeout_o;

  // Pipeline side: drives hazard and memory status, consumes stall/flush controls.
  modport master (
    output IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
           Branch_i, mem_req_i, mem_ack_i,
    input  PCWrite_o, IFIDstall_o, IFIDflush_o, IDEXhold_o, IDEXbubble_o,
           EXMEMhold_o, MEMWBbubble_o, stall_cnt_o, timeout_o
  );

  // Controller side.
  modport slave (
    input  IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
           Branch_i, mem_req_i, mem_ack_i,
    output PCWrite_o, IFIDstall_o, IFIDflush_o, IDEXhold_o, IDEXbubble_o,
           EXMEMhold_o, MEMWBbubble_o, stall_cnt_o, timeout_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates data-cache wait,
// load-use hazard and taken branch; keeps a stall counter and a memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [WAIT_W-1:0]   wait_inc;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                timeout_q;
  logic                mem_stall;
  logic                load_use;
  logic                branch_flush;
  logic                pc_write;

  // State register; reset abandons any outstanding miss.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and hazard arbitration: memory stall > load-use > branch.
  always_comb begin
    state_d      = state_q;
    mem_stall    = 1'b0;
    load_use     = 1'b0;
    branch_flush = 1'b0;
    pc_write     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_i && !bus.mem_ack_i) begin
          state_d   = MEM_WAIT;
          mem_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack_i) state_d = RELEASE;
        else               mem_stall = 1'b1;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load_use = !mem_stall && bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
               ((bus.IDEX_RDaddr_i == bus.IFID_RS1addr_i) ||
                (bus.IDEX_RDaddr_i == bus.IFID_RS2addr_i));
    branch_flush = !mem_stall && !load_use && bus.Branch_i;
    pc_write     = !mem_stall && !load_use;
    if (rst_i) begin
      mem_stall    = 1'b0;
      load_use     = 1'b0;
      branch_flush = 1'b0;
      pc_write     = 1'b0;
    end
  end

  assign bus.PCWrite_o     = pc_write;
  assign bus.IFIDstall_o   = mem_stall | load_use;
  assign bus.IFIDflush_o   = branch_flush;
  assign bus.IDEXhold_o    = mem_stall;
  assign bus.IDEXbubble_o  = load_use;
  assign bus.EXMEMhold_o   = mem_stall;
  assign bus.MEMWBbubble_o = mem_stall;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.timeout_o     = timeout_q;

  assign wait_inc = wait_cnt_q + WAIT_W'(1);

  // MEM_WAIT cycle counter and sticky timeout; the FSM keeps waiting regardless.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == IDLE && state_d == MEM_WAIT) begin
      wait_cnt_q <= '0;
    end else if (state_q == MEM_WAIT) begin
      if (wait_cnt_q != '1) begin
        wait_cnt_q <= wait_inc;
        if (wait_inc == WAIT_W'(TIMEOUT)) timeout_q <= 1'b1;
      end
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  stall_cnt_q <= '0;
    else if (!pc_write && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned TMO = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state: is a miss outstanding, did one just complete,
  // how many cycles has it been waiting, and the observable counters.
  bit          m_waiting;
  bit          m_just_done;
  int          m_wait_cycles;
  logic [31:0] m_stall_cnt;
  bit          m_timeout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, compare outputs, advance the model.
  task automatic step(input bit rst, input bit req, input bit ack, input bit memrd,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit br);
    bit mem_stall, lu, pcw, flush;
    logic [6:0] exp_vec, got_vec;
    @(negedge clk_i);
    rst_i              = rst;
    bus.mem_req_i      = req;
    bus.mem_ack_i      = ack;
    bus.IDEX_MemRead_i = memrd;
    bus.IDEX_RDaddr_i  = rd;
    bus.IFID_RS1addr_i = rs1;
    bus.IFID_RS2addr_i = rs2;
    bus.Branch_i       = br;
    if (rst) begin
      m_waiting = 0; m_just_done = 0; m_wait_cycles = 0;
      m_stall_cnt = 0; m_timeout = 0;
    end
    #1;
    // Frozen while a miss is being requested or still unanswered.
    mem_stall = !rst && !m_just_done && !ack && (m_waiting || req);
    lu    = !rst && !mem_stall && memrd && (rd != 0) && (rd == rs1 || rd == rs2);
    pcw   = !rst && !mem_stall && !lu;
    flush = !rst && !mem_stall && !lu && br;
    exp_vec = {pcw, mem_stall || lu, flush, mem_stall, lu, mem_stall, mem_stall};
    got_vec = {bus.PCWrite_o, bus.IFIDstall_o, bus.IFIDflush_o, bus.IDEXhold_o,
               bus.IDEXbubble_o, bus.EXMEMhold_o, bus.MEMWBbubble_o};
    check("ctrl", 32'(got_vec), 32'(exp_vec));
    check("stall_cnt", bus.stall_cnt_o, m_stall_cnt);
    check("timeout", 32'(bus.timeout_o), 32'(m_timeout));
    if (!rst) begin
      if (!pcw && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
      if (m_waiting) begin
        m_wait_cycles++;
        if (m_wait_cycles >= int'(TMO)) m_timeout = 1;
        if (ack) begin m_waiting = 0; m_just_done = 1; end
      end else if (m_just_done) begin
        m_just_done = 0;
      end else if (req && !ack) begin
        m_waiting = 1; m_wait_cycles = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  initial begin
    logic [31:0] base;
    bus.mem_req_i = 0; bus.mem_ack_i = 0; bus.IDEX_MemRead_i = 0;
    bus.IDEX_RDaddr_i = 0; bus.IFID_RS1addr_i = 0; bus.IFID_RS2addr_i = 0; bus.Branch_i = 0;

    // Reset, then no hazard.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("rst_pcw", 32'(bus.PCWrite_o), 32'd0);
    check("rst_cnt", bus.stall_cnt_o, 32'd0);
    idle(2);
    check("idle_pcw", 32'(bus.PCWrite_o), 32'd1);

    // Load-use on rs2, then the same with rd=0.
    step(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
    check("lu_bubble", 32'(bus.IDEXbubble_o), 32'd1);
    idle(1);
    check("lu_cnt", bus.stall_cnt_o, 32'd1);
    step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    check("lu_rd0_pcw", 32'(bus.PCWrite_o), 32'd1);

    // Miss: ack three cycles after the request, then release, then idle.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("release_pcw", 32'(bus.PCWrite_o), 32'd1);
    idle(1);
    check("miss_cnt", bus.stall_cnt_o, 32'd4);
    // Hit.
    step(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    check("hit_pcw", 32'(bus.PCWrite_o), 32'd1);
    idle(1);

    // Priority: memory stall over load-use and branch, then load-use over branch.
    step(0, 1, 0, 1, 5'd7, 5'd7, 5'd0, 1);
    check("prio_flush", 32'(bus.IFIDflush_o), 32'd0);
    check("prio_bubble", 32'(bus.IDEXbubble_o), 32'd0);
    step(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);
    step(0, 0, 0, 1, 5'd9, 5'd9, 5'd3, 1);
    check("lu_br_flush", 32'(bus.IFIDflush_o), 32'd0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    check("br_flush", 32'(bus.IFIDflush_o), 32'd1);

    // Timeout: long wait, sticky past the ack, cleared by reset mid-wait.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("tmo_set", 32'(bus.timeout_o), 32'd1);
    step(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);
    check("tmo_sticky", 32'(bus.timeout_o), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    check("tmo_rst", 32'(bus.timeout_o), 32'd0);
    step(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    check("late_ack_pcw", 32'(bus.PCWrite_o), 32'd1);
    idle(1);

    // Saturation from a preloaded counter.
    @(negedge clk_i);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_stall_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    check("sat_cnt", bus.stall_cnt_o, 32'hFFFF_FFFF);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);

    // Random traffic with small register indices so hazards collide often.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) == 0), ($urandom_range(2) == 0),
           $urandom_range(1) == 1, 5'($urandom_range(7)), 5'($urandom_range(7)),
           5'($urandom_range(7)), $urandom_range(3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
